id_ctrl: RTL and testbench
==========================

// Module: id_ctrl
// PURPOSE
//  Decode-stage controller of the pipelined RV32I core. Sits between the IF/ID
//  pipeline register and EX. Decodes opcode into imm_sel for imm_gen plus the
//  main control bits, and registers the result into the ID/EX slot.
//  Owns the load-use bubble and the branch-flush drop window.
// PARAMETERS
//  FLUSH_LAT  1  cycles after i_flush during which accepted IF beats are discarded (1..7)
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst_n       in   1   async active-low reset
//  i_if_valid    in   1   IF beat valid
//  o_if_ready    out  1   ID accepts beat this cycle
//  i_if_inst     in   32  instruction
//  i_if_pc       in   32  PC of instruction
//  i_ex_ready    in   1   EX accepts ID/EX slot
//  i_flush       in   1   branch/jump mispredict from EX, one-cycle pulse
//  o_ex_valid    out  1   ID/EX slot valid
//  o_ex_inst     out  32  registered instruction (feeds imm_gen i_inst)
//  o_ex_pc       out  32  registered PC
//  o_imm_sel     out  3   000 I, 001 S, 010 B, 011 J, 100 LUI, 101 AUIPC, 111 none/illegal
//  o_rd_wren     out  1   writes rd (forced 0 when rd==x0)
//  o_opb_imm     out  1   ALU operand B is immediate
//  o_mem_rden    out  1   load
//  o_mem_wren    out  1   store
//  o_br_en       out  1   branch/JAL/JALR
//  o_illegal     out  1   opcode not in RV32I base set
// BEHAVIOUR
//  - Reset: all outputs 0 except o_imm_sel=3'b111; state RUN; flush counter 0.
//  - Decode (combinational on i_if_inst[6:0]): 0010011/0000011/1100111 -> I;
//    0100011 S; 1100011 B; 1101111 J; 0110111 LUI; 0010111 AUIPC; 0110011 R (sel 111,
//    opb_imm 0); anything else -> o_illegal=1, all enables 0, sel 111.
//  - Slot advance: adv = !o_ex_valid | i_ex_ready. Latency 1 cycle IF->EX.
//  - o_if_ready = adv & !hazard. On if_valid & if_ready slot loads decoded beat.
//    On adv with no accepted beat slot goes invalid (o_ex_valid=0, controls 0).
//  - Outputs hold stable while o_ex_valid & !i_ex_ready.
//  - hazard = o_ex_valid & o_mem_rden & rd!=0 & rd matches used rs1 (all except
//    LUI/AUIPC/JAL) or used rs2 (R/S/B). Exactly one bubble inserted; next cycle accepts.
//  - FSM RUN/FLUSH. i_flush in any state: slot invalid next edge, counter=FLUSH_LAT,
//    -> FLUSH. FLUSH: o_if_ready=1, beats consumed but not loaded, counter-- per cycle
//    (beat or not); counter==1 -> RUN. i_flush in FLUSH reloads counter.
//  - i_flush beats hazard and stall; i_flush with i_ex_ready=0 still clears slot.
//  - Reset mid-operation drops slot and flush window immediately (async).
// CONFIGURATION
//  ID_PERF_CNT_EN defined: adds o_bubble_cnt[31:0] and o_flush_cnt[31:0], count
//   load-use bubbles and i_flush pulses, wrap at 2^32, reset to 0.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  Shared pkg rv_pkg: opcode localparams, imm_sel_e enum (encodings above),
//  ctrl_t struct of the control bits. Sub-module id_decode (pure combinational
//  opcode->ctrl_t) instantiated once; FSM, hazard, slot register in id_ctrl.
// TESTING
//  - addi x1,x2,5 (0x00510093) valid, ex_ready=1 -> next cycle ex_valid=1, sel 000, rd_wren=1, opb_imm=1.
//  - lw x5,0(x1) then add x6,x5,x7 back-to-back -> one cycle if_ready=0, ex_valid=0 bubble, add issues cycle after.
//  - lw x0,0(x1) then add x6,x0,x7 -> no bubble; rd_wren=0 on lw.
//  - FLUSH_LAT=2, i_flush with beats streaming -> slot invalid, next 2 beats dropped, 3rd issues.
//  - ex_ready=0 for 3 cycles with slot full -> o_ex_* stable, if_ready=0; i_flush then -> ex_valid=0.
//  - inst 0x0000007F -> o_illegal=1, sel 111, all enables 0; assert i_rst_n=0 mid-FLUSH -> all outputs reset values.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate-format select,
// control-bit bundle and small instruction field helpers.
package rv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_LUI   = 3'b100,
        IMM_AUIPC = 3'b101,
        IMM_NONE  = 3'b111
    } imm_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } id_state_e;

    typedef struct packed {
        imm_sel_e imm_sel;
        logic     rd_wren;
        logic     opb_imm;
        logic     mem_rden;
        logic     mem_wren;
        logic     br_en;
        logic     illegal;
    } ctrl_t;

    // Control word of an empty slot: nothing enabled, no immediate.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c         = '0;
        c.imm_sel = IMM_NONE;
        return c;
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/id_decode.sv
// Pure combinational opcode decoder: opcode -> control bundle plus which
// source registers the instruction actually reads (used for load-use checks).
module id_decode
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       rs1_used,
    output logic       rs2_used
);

    // Opcode table. opb_imm marks formats whose ALU operand B is the
    // immediate; branches keep rs2 on operand B for the compare.
    always_comb begin
        ctrl     = ctrl_idle();
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        unique case (opcode)
            OPC_OP_IMM: begin
                ctrl.imm_sel = IMM_I;
                ctrl.rd_wren = 1'b1;
                ctrl.opb_imm = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.imm_sel  = IMM_I;
                ctrl.rd_wren  = 1'b1;
                ctrl.opb_imm  = 1'b1;
                ctrl.mem_rden = 1'b1;
            end
            OPC_JALR: begin
                ctrl.imm_sel = IMM_I;
                ctrl.rd_wren = 1'b1;
                ctrl.opb_imm = 1'b1;
                ctrl.br_en   = 1'b1;
            end
            OPC_STORE: begin
                ctrl.imm_sel  = IMM_S;
                ctrl.opb_imm  = 1'b1;
                ctrl.mem_wren = 1'b1;
                rs2_used      = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.imm_sel = IMM_B;
                ctrl.br_en   = 1'b1;
                rs2_used     = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_sel = IMM_J;
                ctrl.rd_wren = 1'b1;
                ctrl.opb_imm = 1'b1;
                ctrl.br_en   = 1'b1;
                rs1_used     = 1'b0;
            end
            OPC_LUI: begin
                ctrl.imm_sel = IMM_LUI;
                ctrl.rd_wren = 1'b1;
                ctrl.opb_imm = 1'b1;
                rs1_used     = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel = IMM_AUIPC;
                ctrl.rd_wren = 1'b1;
                ctrl.opb_imm = 1'b1;
                rs1_used     = 1'b0;
            end
            OPC_OP: begin
                ctrl.rd_wren = 1'b1;
                rs2_used     = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl.sv
// Decode-stage controller: decodes the IF beat, registers it into the ID/EX
// slot, inserts one bubble on a load-use hazard and discards FLUSH_LAT beats
// after a branch flush.
// Optional build macro ID_PERF_CNT_EN adds bubble / flush event counters.
module id_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned FLUSH_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_valid,
    output logic        o_if_ready,
    input  logic [31:0] i_if_inst,
    input  logic [31:0] i_if_pc,
    input  logic        i_ex_ready,
    input  logic        i_flush,
    output logic        o_ex_valid,
    output logic [31:0] o_ex_inst,
    output logic [31:0] o_ex_pc,
    output logic [2:0]  o_imm_sel,
    output logic        o_rd_wren,
    output logic        o_opb_imm,
    output logic        o_mem_rden,
    output logic        o_mem_wren,
    output logic        o_br_en,
    output logic        o_illegal
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0] o_bubble_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_LAT);

    id_state_e   state_reg, state_next;
    logic [2:0]  drop_cnt_reg, drop_cnt_next;

    logic        slot_valid_reg, slot_valid_next;
    logic [31:0] slot_inst_reg, slot_inst_next;
    logic [31:0] slot_pc_reg, slot_pc_next;
    ctrl_t       slot_ctrl_reg, slot_ctrl_next;

    ctrl_t       dec_ctrl;
    ctrl_t       beat_ctrl;
    logic        dec_rs1_used, dec_rs2_used;
    logic [4:0]  slot_rd;
    logic        adv, hazard;
    logic        if_ready_int, load_beat, bubble;

    id_decode u_decode (
        .opcode   (i_if_inst[6:0]),
        .ctrl     (dec_ctrl),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Writes to x0 are architecturally discarded, so never request them.
    always_comb begin
        beat_ctrl = dec_ctrl;
        if (inst_rd(i_if_inst) == 5'd0) begin
            beat_ctrl.rd_wren = 1'b0;
        end
    end

    assign slot_rd = inst_rd(slot_inst_reg);
    assign adv     = !slot_valid_reg || i_ex_ready;
    // A load sitting in the slot whose result the incoming beat reads.
    assign hazard  = slot_valid_reg && slot_ctrl_reg.mem_rden && (slot_rd != 5'd0) &&
                     ((dec_rs1_used && (inst_rs1(i_if_inst) == slot_rd)) ||
                      (dec_rs2_used && (inst_rs2(i_if_inst) == slot_rd)));

    // FSM state and drop-window counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_RUN;
            drop_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Next state: a flush always (re)opens the drop window.
    always_comb begin
        state_next    = state_reg;
        drop_cnt_next = drop_cnt_reg;
        if (i_flush) begin
            state_next    = ST_FLUSH;
            drop_cnt_next = FLUSH_LOAD;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    state_next = ST_RUN;
                end
                ST_FLUSH: begin
                    drop_cnt_next = drop_cnt_reg - 3'd1;
                    if (drop_cnt_reg == 3'd1) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // FSM outputs. The beat presented in the flush cycle is wrong-path, so it
    // is consumed and discarded just like the beats in the drop window.
    always_comb begin
        if_ready_int = 1'b0;
        load_beat    = 1'b0;
        bubble       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (i_flush) begin
                    if_ready_int = 1'b1;
                end else begin
                    if_ready_int = adv && !hazard;
                    load_beat    = i_if_valid && adv && !hazard;
                    bubble       = i_if_valid && adv && hazard;
                end
            end
            ST_FLUSH: begin
                if_ready_int = 1'b1;
            end
            default: begin
                if_ready_int = 1'b0;
            end
        endcase
    end

    assign o_if_ready = i_rst_n && if_ready_int;

    // Slot update: load the accepted beat, otherwise empty out whenever the
    // slot drains or a flush/drop is in progress; hold while EX stalls.
    always_comb begin
        slot_valid_next = slot_valid_reg;
        slot_inst_next  = slot_inst_reg;
        slot_pc_next    = slot_pc_reg;
        slot_ctrl_next  = slot_ctrl_reg;
        if (load_beat) begin
            slot_valid_next = 1'b1;
            slot_inst_next  = i_if_inst;
            slot_pc_next    = i_if_pc;
            slot_ctrl_next  = beat_ctrl;
        end else if (i_flush || (state_reg == ST_FLUSH) || adv) begin
            slot_valid_next = 1'b0;
            slot_inst_next  = 32'd0;
            slot_pc_next    = 32'd0;
            slot_ctrl_next  = ctrl_idle();
        end
    end

    // ID/EX slot register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_valid_reg <= 1'b0;
            slot_inst_reg  <= 32'd0;
            slot_pc_reg    <= 32'd0;
            slot_ctrl_reg  <= ctrl_idle();
        end else begin
            slot_valid_reg <= slot_valid_next;
            slot_inst_reg  <= slot_inst_next;
            slot_pc_reg    <= slot_pc_next;
            slot_ctrl_reg  <= slot_ctrl_next;
        end
    end

    assign o_ex_valid = slot_valid_reg;
    assign o_ex_inst  = slot_inst_reg;
    assign o_ex_pc    = slot_pc_reg;
    assign o_imm_sel  = slot_ctrl_reg.imm_sel;
    assign o_rd_wren  = slot_ctrl_reg.rd_wren;
    assign o_opb_imm  = slot_ctrl_reg.opb_imm;
    assign o_mem_rden = slot_ctrl_reg.mem_rden;
    assign o_mem_wren = slot_ctrl_reg.mem_wren;
    assign o_br_en    = slot_ctrl_reg.br_en;
    assign o_illegal  = slot_ctrl_reg.illegal;

`ifdef ID_PERF_CNT_EN
    logic [31:0] bubble_cnt_reg;
    logic [31:0] flush_evt_reg;

    // Event counters, free-running with natural 32-bit wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_reg <= 32'd0;
            flush_evt_reg  <= 32'd0;
        end else begin
            if (bubble) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
            if (i_flush) begin
                flush_evt_reg <= flush_evt_reg + 32'd1;
            end
        end
    end

    assign o_bubble_cnt = bubble_cnt_reg;
    assign o_flush_cnt  = flush_evt_reg;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_ctrl.sv
// Bench for id_ctrl (FLUSH_LAT=2): directed vectors, a per-cycle reference
// model compared on every falling edge, plus literal spot checks.
module tb_id_ctrl;

    localparam int FL = 2;

    localparam logic [31:0] ADDI     = 32'h00510093; // addi x1,x2,5
    localparam logic [31:0] LW5      = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_X5   = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] LW0      = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_X0   = 32'h00700333; // add  x6,x0,x7
    localparam logic [31:0] SW_X2    = 32'h0020A023; // sw   x2,0(x1)
    localparam logic [31:0] SW_X5    = 32'h0050A023; // sw   x5,0(x1)
    localparam logic [31:0] BEQ      = 32'h00208063; // beq  x1,x2,0
    localparam logic [31:0] JAL      = 32'h000000EF; // jal  x1,0
    localparam logic [31:0] JALR     = 32'h000100E7; // jalr x1,0(x2)
    localparam logic [31:0] LUI3     = 32'h000011B7; // lui  x3,1
    localparam logic [31:0] LUI_RS5  = 32'h000281B7; // lui  x3,0x28 (bits 19:15 = 5)
    localparam logic [31:0] AUIPC4   = 32'h00000217; // auipc x4,0
    localparam logic [31:0] ILL      = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = 32'd0;
    logic [31:0] if_pc = 32'd0;
    logic        ex_ready = 1'b0;
    logic        flush = 1'b0;
    logic        if_ready, ex_valid;
    logic [31:0] ex_inst, ex_pc;
    logic [2:0]  imm_sel;
    logic        rd_wren, opb_imm, mem_rden, mem_wren, br_en, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ctrl #(.FLUSH_LAT(FL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(if_ready),
        .i_if_inst(if_inst), .i_if_pc(if_pc), .i_ex_ready(ex_ready), .i_flush(flush),
        .o_ex_valid(ex_valid), .o_ex_inst(ex_inst), .o_ex_pc(ex_pc), .o_imm_sel(imm_sel),
        .o_rd_wren(rd_wren), .o_opb_imm(opb_imm), .o_mem_rden(mem_rden),
        .o_mem_wren(mem_wren), .o_br_en(br_en), .o_illegal(illegal)
    );

    // Expected control word {sel[2:0], rd_wren, opb_imm, mem_rden, mem_wren, br_en, illegal}.
    function automatic logic [8:0] ref_dec(input logic [31:0] inst);
        logic [8:0] r;
        case (inst[6:0])
            7'b0010011: r = 9'b000_110000;
            7'b0000011: r = 9'b000_111000;
            7'b1100111: r = 9'b000_110010;
            7'b0100011: r = 9'b001_010100;
            7'b1100011: r = 9'b010_000010;
            7'b1101111: r = 9'b011_110010;
            7'b0110111: r = 9'b100_110000;
            7'b0010111: r = 9'b101_110000;
            7'b0110011: r = 9'b111_100000;
            default:    r = 9'b111_000001;
        endcase
        if (inst[11:7] == 5'd0) r[5] = 1'b0;
        return r;
    endfunction

    // Load in slot whose destination the new instruction reads.
    function automatic bit ref_hz(input bit sv, input logic [31:0] si, input logic [31:0] ni);
        logic [8:0] d;
        logic [6:0] op;
        bit u1, u2;
        d  = ref_dec(si);
        op = ni[6:0];
        u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return sv && d[3] && (si[11:7] != 5'd0) &&
               ((u1 && ni[19:15] == si[11:7]) || (u2 && ni[24:20] == si[11:7]));
    endfunction

    // Reference model: what the slot should hold and how many beats remain to drop.
    bit          m_valid = 1'b0;
    logic [31:0] m_inst = 32'd0;
    logic [31:0] m_pc = 32'd0;
    int          m_drop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_inst  <= 32'd0;
            m_pc    <= 32'd0;
            m_drop  <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_drop  <= FL;
        end else if (m_drop > 0) begin
            m_valid <= 1'b0;
            m_drop  <= m_drop - 1;
        end else if (!m_valid || ex_ready) begin
            if (if_valid && !ref_hz(m_valid, m_inst, if_inst)) begin
                m_valid <= 1'b1;
                m_inst  <= if_inst;
                m_pc    <= if_pc;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    logic [8:0] m_exp;
    logic       m_rdy;
    assign m_exp = m_valid ? ref_dec(m_inst) : 9'h1C0;
    assign m_rdy = rst_n && (flush || (m_drop > 0) ||
                   ((!m_valid || ex_ready) && !ref_hz(m_valid, m_inst, if_inst)));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge.
    always @(negedge clk) begin
        chk("m_if_ready", {31'd0, if_ready}, {31'd0, m_rdy});
        chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("m_ctrl", {23'd0, imm_sel, rd_wren, opb_imm, mem_rden, mem_wren, br_en, illegal},
            {23'd0, m_exp});
        if (m_valid) begin
            chk("m_ex_inst", ex_inst, m_inst);
            chk("m_ex_pc", ex_pc, m_pc);
        end
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic er, input logic fl);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        ex_ready = er;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("txn t=%0t v=%b inst=%h pc=%h exr=%b fl=%b -> ex_v=%b ex_pc=%h sel=%b",
                 $time, if_valid, if_inst, if_pc, ex_ready, flush, ex_valid, ex_pc, imm_sel);
    endtask

    typedef struct { logic [31:0] inst; logic [31:0] pc; } beat_t;
    beat_t stream [9];

    initial begin
        stream[0] = '{JAL,     32'h608};
        stream[1] = '{JALR,    32'h60C};
        stream[2] = '{LUI3,    32'h610};
        stream[3] = '{AUIPC4,  32'h614};
        stream[4] = '{LW5,     32'h618};
        stream[5] = '{SW_X5,   32'h61C};
        stream[6] = '{SW_X5,   32'h61C};
        stream[7] = '{LW5,     32'h620};
        stream[8] = '{LUI_RS5, 32'h624};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_imm_sel", {29'd0, imm_sel}, 32'd7);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        rst_n = 1'b1;

        // addi issues one cycle later
        drive(1, ADDI, 32'h100, 1, 0); tick();
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_sel", {29'd0, imm_sel}, 32'd0);
        chk("addi_rd_wren", {31'd0, rd_wren}, 32'd1);
        chk("addi_opb_imm", {31'd0, opb_imm}, 32'd1);
        chk("addi_pc", ex_pc, 32'h100);

        // Load-use: exactly one bubble
        drive(1, LW5, 32'h104, 1, 0); tick();
        chk("lw_rden", {31'd0, mem_rden}, 32'd1);
        drive(1, ADD_X5, 32'h108, 1, 0); #1;
        chk("lu_stall_ready", {31'd0, if_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_ready_after", {31'd0, if_ready}, 32'd1);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_inst", ex_inst, ADD_X5);
        chk("lu_add_sel", {29'd0, imm_sel}, 32'd7);
        chk("lu_add_opb", {31'd0, opb_imm}, 32'd0);

        // Load to x0: no hazard, no register write
        drive(1, LW0, 32'h10C, 1, 0); tick();
        chk("lw0_rd_wren", {31'd0, rd_wren}, 32'd0);
        drive(1, ADD_X0, 32'h110, 1, 0); #1;
        chk("lw0_no_stall", {31'd0, if_ready}, 32'd1);
        tick();
        chk("lw0_add_pc", ex_pc, 32'h110);

        // EX stall for three cycles holds the slot
        drive(1, ADDI, 32'h114, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {31'd0, if_ready}, 32'd0);
            tick();
            chk("stall_inst", ex_inst, ADD_X0);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        // Flush while stalled still empties the slot
        drive(1, ADDI, 32'h114, 0, 1); tick();
        chk("stall_flush", {31'd0, ex_valid}, 32'd0);
        drive(1, ADDI, 32'h200, 1, 0); tick();
        chk("drop1", {31'd0, ex_valid}, 32'd0);
        drive(1, ADDI, 32'h204, 1, 0); tick();
        chk("drop2", {31'd0, ex_valid}, 32'd0);
        drive(1, ADDI, 32'h208, 1, 0); tick();
        chk("post_drop_pc", ex_pc, 32'h208);

        // Flush with beats streaming, then a flush inside the window
        drive(1, ADDI, 32'h20C, 1, 1); tick();
        drive(1, ADDI, 32'h210, 1, 0); tick();
        drive(1, ADDI, 32'h214, 1, 1); tick();
        drive(1, ADDI, 32'h218, 1, 0); tick();
        drive(1, ADDI, 32'h21C, 1, 0); tick();
        chk("reload_drop", {31'd0, ex_valid}, 32'd0);
        drive(1, ADDI, 32'h220, 1, 0); tick();
        chk("reload_issue_pc", ex_pc, 32'h220);

        // Illegal opcode
        drive(1, ILL, 32'h400, 1, 0); tick();
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_ctrl", {26'd0, imm_sel, rd_wren, opb_imm, mem_rden}, {26'd0, 3'b111, 3'b000});
        chk("ill_ctrl2", {30'd0, mem_wren, br_en}, 32'd0);

        // Other formats
        drive(1, SW_X2, 32'h600, 1, 0); tick();
        chk("sw_sel", {29'd0, imm_sel}, 32'd1);
        chk("sw_wren", {31'd0, mem_wren}, 32'd1);
        drive(1, BEQ, 32'h604, 1, 0); tick();
        chk("beq_sel", {29'd0, imm_sel}, 32'd2);
        chk("beq_br", {31'd0, br_en}, 32'd1);
        foreach (stream[i]) begin
            drive(1, stream[i].inst, stream[i].pc, 1, 0);
            tick();
        end

        // Async reset with a full slot
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_sel", {29'd0, imm_sel}, 32'd7);
        chk("arst_ready", {31'd0, if_ready}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Reset in the middle of a drop window cancels it
        drive(1, ADDI, 32'h500, 1, 1); tick();
        rst_n = 1'b0;
        #1;
        chk("flush_rst_ready", {31'd0, if_ready}, 32'd0);
        chk("flush_rst_ill", {31'd0, illegal}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1, ADDI, 32'h504, 1, 0); tick();
        chk("post_rst_issue", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_pc", ex_pc, 32'h504);

        drive(0, 32'd0, 32'd0, 1, 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
